// File: rtl/decos_suma_seq.sv
// Time-multiplexed ones-count sequencer: captures an oversampled frame, then streams
// LANES per-sample sums per beat and mirrors them into a parallel result register.
module decos_suma_seq #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    parameter int LANES   = 4,
    localparam int SUMW   = $clog2(OSF + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [SAMPLES*OSF-1:0]    frame_in,
    output logic                      busy,
    output logic                      done,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*SUMW-1:0]     m_data,
    output logic                      m_last,
    output logic [SAMPLES*SUMW-1:0]   sums_out
);

    localparam int GROUPS = SAMPLES / LANES;
    localparam int GW     = $clog2(GROUPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [SAMPLES*OSF-1:0]     r_shadow;
    logic [GW-1:0]              r_grp;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_m_valid;
    logic                       r_m_last;
    logic [LANES*SUMW-1:0]      r_m_data;
    logic [SAMPLES*SUMW-1:0]    r_sums;

    logic                       w_start;
    logic                       w_abort;
    logic                       w_load;
    logic                       w_last_acc;
    logic                       w_grp_left;
    logic                       w_is_last_grp;
    logic [LANES*SUMW-1:0]      w_grp_sums;
    int                         w_slice_base;

    function automatic logic [SUMW-1:0] f_popcount(input logic [OSF-1:0] smp);
        logic [SUMW-1:0] cnt;
        cnt = {SUMW{1'b0}};
        for (int i = 0; i < OSF; i++) begin
            cnt = cnt + {{(SUMW-1){1'b0}}, smp[i]};
        end
        return cnt;
    endfunction

    // Ones-count of the LANES samples selected by the current group index
    always_comb begin
        int grp_idx;
        w_grp_sums   = {(LANES*SUMW){1'b0}};
        grp_idx      = 0;
        if (w_grp_left) begin
            grp_idx = int'(r_grp);
        end else begin
            grp_idx = 0;
        end
        w_slice_base = grp_idx * LANES * SUMW;
        for (int l = 0; l < LANES; l++) begin
            w_grp_sums[l*SUMW +: SUMW] = f_popcount(r_shadow[(grp_idx*LANES + l)*OSF +: OSF]);
        end
    end

    // Handshake and load qualifiers; abort in RUN suppresses both load and accept
    always_comb begin
        w_grp_left    = (r_grp < GW'(GROUPS));
        w_is_last_grp = (r_grp == GW'(GROUPS - 1));
        w_start       = (r_state == S_IDLE) && start;
        w_abort       = (r_state == S_RUN) && abort;
        w_last_acc    = (r_state == S_RUN) && !abort && r_m_valid && m_ready && r_m_last;
        w_load        = (r_state == S_RUN) && !abort && (!r_m_valid || m_ready) && w_grp_left;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_acc) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame shadow, group walker, stream register and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= {(SAMPLES*OSF){1'b0}};
            r_grp     <= {GW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= {(LANES*SUMW){1'b0}};
            r_sums    <= {(SAMPLES*SUMW){1'b0}};
        end else begin
            r_done <= w_last_acc;
            if (w_start) begin
                r_shadow <= frame_in;
                r_grp    <= {GW{1'b0}};
                r_busy   <= 1'b1;
            end else if (w_abort || w_last_acc) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_load) begin
                r_m_data  <= w_grp_sums;
                r_sums[w_slice_base +: LANES*SUMW] <= w_grp_sums;
                r_m_last  <= w_is_last_grp;
                r_m_valid <= 1'b1;
                r_grp     <= r_grp + {{(GW-1){1'b0}}, 1'b1};
            end else if ((r_state == S_RUN) && r_m_valid && m_ready) begin
                // Defensive: an accepted non-last beat always reloads, so this only drains
                r_m_valid <= 1'b0;
            end else begin
                r_m_valid <= r_m_valid;
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        busy     = r_busy;
        done     = r_done;
        m_valid  = r_m_valid;
        m_last   = r_m_last;
        m_data   = r_m_data;
        sums_out = r_sums;
    end

endmodule

// File: tb/tb_decos_suma_seq.sv
// Directed bench for decos_suma_seq: table of frame/ready scenarios plus hand-written
// start-spam, abort and mid-run reset sequences, all checked against a bench-side model.
module tb_decos_suma_seq;

    localparam int SAMPLES = 128;
    localparam int OSF     = 8;
    localparam int LANES   = 4;
    localparam int SUMW    = 4;
    localparam int GROUPS  = 32;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    logic                      abort;
    logic [SAMPLES*OSF-1:0]    frame_in;
    logic                      busy;
    logic                      done;
    logic                      m_valid;
    logic                      m_ready;
    logic [LANES*SUMW-1:0]     m_data;
    logic                      m_last;
    logic [SAMPLES*SUMW-1:0]   sums_out;

    int n_checks;
    int n_errors;

    decos_suma_seq #(.SAMPLES(SAMPLES), .OSF(OSF), .LANES(LANES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .frame_in (frame_in),
        .busy     (busy),
        .done     (done),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .sums_out (sums_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          mode;
        logic [15:0] exp_g0;
        logic [3:0]  exp_s7;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] pc(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) c = c + 4'd1;
        end
        return c;
    endfunction

    function automatic logic [1023:0] mk_frame(input int kind);
        logic [1023:0] f;
        f = '0;
        for (int s = 0; s < SAMPLES; s++) begin
            case (kind)
                0:       f[s*8 +: 8] = 8'hFF;
                1:       f[s*8 +: 8] = 8'(s);
                2:       f[s*8 +: 8] = 8'hA5;
                3:       f[s*8 +: 8] = 8'(255 - s);
                default: f[s*8 +: 8] = 8'h00;
            endcase
        end
        return f;
    endfunction

    function automatic logic [15:0] exp_beat(input logic [1023:0] f, input int g);
        logic [15:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            r[l*4 +: 4] = pc(f[(g*LANES + l)*8 +: 8]);
        end
        return r;
    endfunction

    function automatic logic [511:0] exp_sums(input logic [1023:0] f);
        logic [511:0] r;
        r = '0;
        for (int s = 0; s < SAMPLES; s++) begin
            r[s*4 +: 4] = pc(f[s*8 +: 8]);
        end
        return r;
    endfunction

    // mode: 0 ready high, 1 ready pattern, 2 ready high with start held and frame changed
    task automatic run(input logic [1023:0] f, input int mode, input int abort_at,
                       input int rst_at, input logic [15:0] exp_g0, input logic [3:0] exp_s7);
        int          beats;
        int          first_v;
        int          done_cyc;
        logic        stall;
        logic [15:0] hold;
        logic        hold_last;
        logic [15:0] pat;
        logic [511:0] s_snap;
        pat = 16'b1001_1010_0111_0001;
        @(negedge clk);
        frame_in = f;
        start    = 1'b1;
        m_ready  = 1'b0;
        @(posedge clk);
        #1;
        start    = (mode == 2);
        frame_in = (mode == 2) ? ~f : f;
        beats    = 0;
        first_v  = -1;
        done_cyc = -1;
        stall    = 1'b0;
        hold     = '0;
        hold_last = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (m_valid && first_v < 0) first_v = cyc;
            if (stall) begin
                chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, hold_last, hold});
            end
            if (done) begin
                done_cyc = cyc;
                start = 1'b0;
                break;
            end
            if (abort_at >= 0 && beats == abort_at) begin
                abort   = 1'b1;
                m_ready = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                chk("abort_outputs", {m_valid, m_last, busy, done}, 4'b0000);
                chk("abort_keeps_s0", sums_out[3:0], pc(f[7:0]));
                @(negedge clk);
                chk("abort_no_done", {busy, done, m_valid}, 3'b000);
                m_ready = 1'b0;
                return;
            end
            if (rst_at >= 0 && beats == rst_at && m_valid) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_ctrl", {m_valid, busy, done, m_last, m_data}, 20'h0);
                chk("rst_mid_sums", sums_out, 512'h0);
                @(negedge clk);
                rst_n   = 1'b1;
                m_ready = 1'b0;
                start   = 1'b0;
                return;
            end
            m_ready = (mode == 1) ? pat[cyc % 16] : 1'b1;
            if (m_valid && m_ready) begin
                chk("beat_data", m_data, exp_beat(f, beats));
                chk("beat_last", m_last, (beats == GROUPS - 1));
                if (beats == 0) chk("group0_const", m_data, exp_g0);
                beats++;
            end
            stall     = m_valid && !m_ready;
            hold      = m_data;
            hold_last = m_last;
        end
        chk("done_seen", (done_cyc >= 0), 1'b1);
        chk("beats_at_done", beats, GROUPS);
        chk("first_valid_latency", first_v, 1);
        if (mode != 1) chk("done_cycle", done_cyc, 33);
        chk("done_state", {busy, m_valid, m_last}, 3'b000);
        chk("sums_model", sums_out, exp_sums(f));
        chk("sums_s7_const", sums_out[7*4 +: 4], exp_s7);
        s_snap = sums_out;
        m_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse_one", {done, busy}, 2'b00);
        chk("sums_hold", sums_out, s_snap);
    endtask

    vec_t tbl [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        m_ready  = 1'b0;
        frame_in = '0;

        tbl[0] = '{kind: 0, mode: 0, exp_g0: 16'h8888, exp_s7: 4'h8};
        tbl[1] = '{kind: 1, mode: 0, exp_g0: 16'h2110, exp_s7: 4'h3};
        tbl[2] = '{kind: 1, mode: 1, exp_g0: 16'h2110, exp_s7: 4'h3};
        tbl[3] = '{kind: 3, mode: 1, exp_g0: 16'h6778, exp_s7: 4'h5};
        tbl[4] = '{kind: 2, mode: 0, exp_g0: 16'h4444, exp_s7: 4'h4};

        #2;
        chk("reset_ctrl", {busy, done, m_valid, m_last, m_data}, 20'h0);
        chk("reset_sums", sums_out, 512'h0);
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_idle", {busy, done, m_valid}, 3'b000);

        for (int i = 0; i < 5; i++) begin
            run(mk_frame(tbl[i].kind), tbl[i].mode, -1, -1, tbl[i].exp_g0, tbl[i].exp_s7);
        end

        run(mk_frame(1), 2, -1, -1, 16'h2110, 4'h3);

        run(mk_frame(0), 0, 10, -1, 16'h8888, 4'h8);
        run(mk_frame(3), 1, -1, -1, 16'h6778, 4'h5);

        run(mk_frame(2), 0, -1, 5, 16'h4444, 4'h4);
        run(mk_frame(1), 0, -1, -1, 16'h2110, 4'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
